apb_axi_lite_bridge: RTL and testbench

APB-to-AXI-lite bridge: an APB completer that converts each APB read or write into a single AXI-lite master transaction. It is the reverse of the AXI-lite-to-APB bridge and lets an APB-side initiator reach AXI-lite targets on the same fabric. The bridge handles one transfer at a time and holds PREADY low until the AXI response has been taken. AXI error responses are mapped onto PSLVERR.

---
 rtl/apb_axi_lite_bridge_if.sv | 51 +++++
 rtl/apb_axi_lite_bridge.sv | 158 +++++++++++++++
 tb/tb_apb_axi_lite_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_axi_lite_bridge_if.sv
// Bus bundle for the APB-to-AXI-lite bridge: APB completer side plus AXI-lite
// master side. The bridge uses the slave modport; the surrounding fabric
// (APB initiator and AXI-lite target) uses the master modport.
interface apb_axi_lite_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    logic [ADDR_WIDTH-1:0] AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0] WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR,
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR,
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/apb_axi_lite_bridge.sv
// APB completer that turns each APB access into one AXI-lite transaction.
// One transfer in flight at a time; PREADY pulses for a single cycle once the
// AXI response has been accepted. BRESP/RRESP bit 1 (SLVERR/DECERR) maps to
// PSLVERR. All outputs are registered.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE    0 | waiting for an APB setup phase
// WR_REQ  1 | AWVALID/WVALID outstanding, each drops after its handshake
// WR_RESP 2 | BREADY high, waiting for BVALID
// RD_REQ  3 | ARVALID high, waiting for ARREADY
// RD_RESP 4 | RREADY high, waiting for RVALID
// DONE    5 | PREADY/PSLVERR presented for one cycle
module apb_axi_lite_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    apb_axi_lite_bridge_if.slave bus,
    output logic [2:0]           state
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  w_setup;
    logic                  w_aw_done;
    logic                  w_w_done;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_arvalid;
    logic                  r_bready;
    logic                  r_rready;
    logic                  r_pready;
    logic                  r_pslverr;

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode; a write channel counts as done once its VALID has
    // already dropped or is handshaking on this edge
    always_comb begin
        w_next    = r_state;
        w_setup   = bus.PSEL && !bus.PENABLE;
        w_aw_done = !r_awvalid || bus.AWREADY;
        w_w_done  = !r_wvalid || bus.WREADY;
        case (r_state)
            S_IDLE:    if (w_setup) w_next = bus.PWRITE ? S_WR_REQ : S_RD_REQ;
            S_WR_REQ:  if (w_aw_done && w_w_done) w_next = S_WR_RESP;
            S_WR_RESP: if (bus.BVALID) w_next = S_DONE;
            S_RD_REQ:  if (bus.ARREADY) w_next = S_RD_RESP;
            S_RD_RESP: if (bus.RVALID) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Registered outputs, updated alongside the state transitions
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_prdata  <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_bready  <= 1'b0;
            r_rready  <= 1'b0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_addr    <= bus.PADDR;
                        r_wdata   <= bus.PWDATA;
                        r_wstrb   <= bus.PSTRB;
                        r_awvalid <= bus.PWRITE;
                        r_wvalid  <= bus.PWRITE;
                        r_arvalid <= !bus.PWRITE;
                    end
                end
                S_WR_REQ: begin
                    if (bus.AWREADY) r_awvalid <= 1'b0;
                    if (bus.WREADY)  r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) r_bready <= 1'b1;
                end
                S_WR_RESP: begin
                    if (bus.BVALID) begin
                        r_bready  <= 1'b0;
                        r_pready  <= 1'b1;
                        r_pslverr <= bus.BRESP[1];
                    end
                end
                S_RD_REQ: begin
                    if (bus.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (bus.RVALID) begin
                        r_rready  <= 1'b0;
                        r_prdata  <= bus.RDATA;
                        r_pready  <= 1'b1;
                        r_pslverr <= bus.RRESP[1];
                    end
                end
                S_DONE: begin
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
                default: begin
                    r_awvalid <= 1'b0;
                    r_wvalid  <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_bready  <= 1'b0;
                    r_rready  <= 1'b0;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                end
            endcase
        end
    end

    assign bus.AWADDR  = r_addr;
    assign bus.ARADDR  = r_addr;
    assign bus.WDATA   = r_wdata;
    assign bus.WSTRB   = r_wstrb;
    assign bus.AWVALID = r_awvalid;
    assign bus.WVALID  = r_wvalid;
    assign bus.ARVALID = r_arvalid;
    assign bus.BREADY  = r_bready;
    assign bus.RREADY  = r_rready;
    assign bus.PRDATA  = r_prdata;
    assign bus.PREADY  = r_pready;
    assign bus.PSLVERR = r_pslverr;
    assign state       = r_state;
endmodule

// File: tb/tb_apb_axi_lite_bridge.sv
// Bench for the APB-to-AXI-lite bridge. An APB initiator and a configurable
// AXI-lite target are driven cycle by cycle on the falling edge; expected
// APB completions are queued when stimulus is issued and popped on PREADY.
module tb_apb_axi_lite_bridge;
    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [2:0] state;

    apb_axi_lite_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    apb_axi_lite_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus),
        .state  (state)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic        slverr;
        logic [31:0] prdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_prdata;
    int          n_checks = 0;
    int          n_fail   = 0;

    int          obs_done, aw_hs, w_hs, ar_hs, r_hs, b_hs, bready_first, aw_only;
    logic        obs_slverr;
    logic [31:0] obs_prdata;
    logic        stable_ok, slverr_ok;
    int          trace[$];

    // Reference model: a read replaces PRDATA, a write keeps it; bit 1 of the
    // response is the error flag.
    task automatic push_exp(input logic wr, input logic [1:0] resp, input logic [31:0] rd);
        exp_t e;
        if (!wr) m_prdata = rd;
        e.slverr = resp[1];
        e.prdata = m_prdata;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PSTRB = '0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
        bus.BVALID = 0; bus.RVALID = 0; bus.BRESP = 2'b00; bus.RRESP = 2'b00; bus.RDATA = '0;
    endtask

    // One APB transfer against an AXI target with programmable latencies.
    // Starts at a falling edge (cycle 0 = setup) and returns at the falling
    // edge of the cycle where PREADY was seen, or after a bounded budget.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [3:0] strb, input int aw_lat, input int w_lat,
                            input int b_lat, input int ar_lat, input int r_lat,
                            input logic [1:0] resp, input logic [31:0] rd);
        int aw_cnt = 0;
        int w_cnt = 0;
        int ar_cnt = 0;
        int wr_done;
        obs_done = -1; aw_hs = -1; w_hs = -1; ar_hs = -1; r_hs = -1; b_hs = -1;
        bready_first = -1; aw_only = 0; stable_ok = 1; slverr_ok = 1;
        obs_slverr = 1'bx; obs_prdata = 'x;
        trace.delete();
        for (int c = 0; c < 60; c++) begin
            if (c > 0) @(negedge ACLK);
            trace.push_back(int'(state));
            if (bus.PSLVERR && !bus.PREADY) slverr_ok = 0;
            if (c > 0 && bus.PREADY) begin
                obs_done = c; obs_slverr = bus.PSLVERR; obs_prdata = bus.PRDATA;
                bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0; bus.BVALID = 0; bus.RVALID = 0;
                break;
            end
            if (bus.AWVALID && bus.AWADDR !== addr) stable_ok = 0;
            if (bus.WVALID && (bus.WDATA !== wd || bus.WSTRB !== strb)) stable_ok = 0;
            if (bus.ARVALID && bus.ARADDR !== addr) stable_ok = 0;
            if (bus.BREADY && bready_first < 0) bready_first = c;
            if (bus.AWVALID && !bus.WVALID) aw_only++;
            bus.PSEL = 1; bus.PENABLE = (c > 0); bus.PWRITE = wr;
            bus.PADDR = addr; bus.PWDATA = wd; bus.PSTRB = strb;
            bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_lat);
            if (bus.AWVALID) begin
                if (bus.AWREADY) aw_hs = c;
                aw_cnt++;
            end
            bus.WREADY = bus.WVALID && (w_cnt >= w_lat);
            if (bus.WVALID) begin
                if (bus.WREADY) w_hs = c;
                w_cnt++;
            end
            wr_done = (aw_hs > w_hs) ? aw_hs : w_hs;
            bus.BVALID = (aw_hs >= 0) && (w_hs >= 0) && (b_hs < 0) && (c - wr_done - 1 >= b_lat);
            bus.BRESP = resp;
            if (bus.BVALID && bus.BREADY) b_hs = c;
            bus.ARREADY = bus.ARVALID && (ar_cnt >= ar_lat);
            if (bus.ARVALID) begin
                if (bus.ARREADY) ar_hs = c;
                ar_cnt++;
            end
            bus.RVALID = (ar_hs >= 0) && (r_hs < 0) && (c - ar_hs - 1 >= r_lat);
            bus.RDATA = rd; bus.RRESP = resp;
            if (bus.RVALID && bus.RREADY) r_hs = c;
        end
    endtask

    task automatic apb_idle();
        @(negedge ACLK);
        clear_inputs();
    endtask

    task automatic test_reset();
        exp_t e;
        ARESET = 1;
        clear_inputs();
        m_prdata = '0;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if ({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.PREADY, bus.PSLVERR,
             bus.PRDATA, bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got state=%0d prdata=%h awaddr=%h valids=%b, want all zero",
                     state, bus.PRDATA, bus.AWADDR, {bus.AWVALID, bus.WVALID, bus.ARVALID});
        end
        ARESET = 0;
        // access-phase-only input in IDLE must be ignored
        bus.PSEL = 1; bus.PENABLE = 1; bus.PWRITE = 1;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if (state !== 3'd0 || bus.AWVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: got state=%0d awvalid=%b, want 0 0", state, bus.AWVALID);
        end
        clear_inputs();
        @(negedge ACLK);
        e.slverr = 0;
        if (sb.size() != 0) sb.delete();
    endtask

    task automatic test_write_zero_wait();
        exp_t e;
        int   exp_tr[4] = '{0, 1, 2, 5};
        push_exp(1, 2'b00, '0);
        apb_xfer(1, 32'h1000, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, '0);
        n_checks++;
        if (obs_done !== 3) begin
            n_fail++; $display("FAIL wr0_pready_cycle: got %0d want 3", obs_done);
        end
        n_checks++;
        if (aw_hs !== 1 || w_hs !== 1 || b_hs !== 2) begin
            n_fail++; $display("FAIL wr0_handshakes: got aw=%0d w=%0d b=%0d want 1 1 2", aw_hs, w_hs, b_hs);
        end
        n_checks++;
        if (stable_ok !== 1'b1) begin
            n_fail++; $display("FAIL wr0_aw_w_payload: got unstable/wrong, want AWADDR=1000 WDATA=deadbeef WSTRB=f");
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (trace[i] !== exp_tr[i]) begin
                n_fail++; $display("FAIL wr0_state_seq[%0d]: got %0d want %0d", i, trace[i], exp_tr[i]);
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (obs_slverr !== e.slverr || obs_prdata !== e.prdata) begin
            n_fail++; $display("FAIL wr0_completion: got slverr=%b prdata=%h want %b %h",
                               obs_slverr, obs_prdata, e.slverr, e.prdata);
        end
        apb_idle();
        n_checks++;
        if (state !== 3'd0 || bus.PREADY !== 1'b0) begin
            n_fail++; $display("FAIL wr0_back_to_idle: got state=%0d pready=%b want 0 0", state, bus.PREADY);
        end
    endtask

    task automatic test_read_zero_wait();
        exp_t e;
        push_exp(0, 2'b00, 32'hA5A55A5A);
        apb_xfer(0, 32'h2004, '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hA5A55A5A);
        n_checks++;
        if (obs_done !== 3 || ar_hs !== 1 || r_hs !== 2) begin
            n_fail++; $display("FAIL rd0_timing: got pready=%0d ar=%0d r=%0d want 3 1 2", obs_done, ar_hs, r_hs);
        end
        n_checks++;
        if (stable_ok !== 1'b1 || bus.ARADDR !== 32'h2004) begin
            n_fail++; $display("FAIL rd0_araddr: got %h stable=%b want 2004", bus.ARADDR, stable_ok);
        end
        e = sb.pop_front();
        n_checks++;
        if (obs_slverr !== e.slverr || obs_prdata !== e.prdata) begin
            n_fail++; $display("FAIL rd0_completion: got slverr=%b prdata=%h want %b %h",
                               obs_slverr, obs_prdata, e.slverr, e.prdata);
        end
        apb_idle();
    endtask

    task automatic test_split_write();
        exp_t e;
        push_exp(1, 2'b00, '0);
        apb_xfer(1, 32'h1100, 32'h0123CAFE, 4'h5, 3, 0, 0, 0, 0, 2'b00, '0);
        n_checks++;
        if (w_hs !== 1 || aw_hs !== 4) begin
            n_fail++; $display("FAIL split_hs: got w=%0d aw=%0d want 1 4", w_hs, aw_hs);
        end
        n_checks++;
        if (aw_only !== 3) begin
            n_fail++; $display("FAIL split_wvalid_drop: got %0d AW-only cycles want 3", aw_only);
        end
        n_checks++;
        if (bready_first !== 5) begin
            n_fail++; $display("FAIL split_bready: got first cycle %0d want 5", bready_first);
        end
        n_checks++;
        if (obs_done !== 6 || stable_ok !== 1'b1) begin
            n_fail++; $display("FAIL split_pready: got cycle %0d stable=%b want 6 1", obs_done, stable_ok);
        end
        e = sb.pop_front();
        n_checks++;
        if (obs_slverr !== e.slverr || obs_prdata !== e.prdata) begin
            n_fail++; $display("FAIL split_completion: got slverr=%b prdata=%h want %b %h",
                               obs_slverr, obs_prdata, e.slverr, e.prdata);
        end
        apb_idle();
    endtask

    task automatic test_error_mapping();
        exp_t        e;
        logic [1:0]  resp_t[4] = '{2'b10, 2'b11, 2'b00, 2'b01};
        logic        wr_t[4]   = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] rd_t[4]   = '{32'h0, 32'h12345678, 32'h0BADF00D, 32'h600DD00D};
        for (int i = 0; i < 4; i++) begin
            push_exp(wr_t[i], resp_t[i], rd_t[i]);
            apb_xfer(wr_t[i], 32'h4000 + 32'(i * 4), 32'h55AA0000 + 32'(i), 4'hF,
                     0, 1, 1, 1, 0, resp_t[i], rd_t[i]);
            e = sb.pop_front();
            n_checks++;
            if (obs_slverr !== e.slverr || obs_prdata !== e.prdata || obs_done < 0) begin
                n_fail++; $display("FAIL err_map[%0d]: got slverr=%b prdata=%h done=%0d want %b %h",
                                   i, obs_slverr, obs_prdata, obs_done, e.slverr, e.prdata);
            end
            n_checks++;
            if (slverr_ok !== 1'b1) begin
                n_fail++; $display("FAIL err_qualify[%0d]: got PSLVERR high without PREADY, want low", i);
            end
            apb_idle();
            n_checks++;
            if (bus.PSLVERR !== 1'b0) begin
                n_fail++; $display("FAIL err_clear[%0d]: got %b want 0", i, bus.PSLVERR);
            end
        end
    endtask

    task automatic test_back_pressure();
        exp_t e;
        push_exp(0, 2'b00, 32'hFEEDFACE);
        apb_xfer(0, 32'h5008, '0, 4'h0, 0, 0, 0, 4, 2, 2'b00, 32'hFEEDFACE);
        n_checks++;
        if (ar_hs !== 5 || r_hs !== 8) begin
            n_fail++; $display("FAIL bp_hs: got ar=%0d r=%0d want 5 8", ar_hs, r_hs);
        end
        n_checks++;
        if (obs_done !== 9) begin
            n_fail++; $display("FAIL bp_pready: got cycle %0d want 9", obs_done);
        end
        n_checks++;
        if (stable_ok !== 1'b1) begin
            n_fail++; $display("FAIL bp_araddr_stable: got unstable, want 5008 throughout");
        end
        e = sb.pop_front();
        n_checks++;
        if (obs_slverr !== e.slverr || obs_prdata !== e.prdata) begin
            n_fail++; $display("FAIL bp_completion: got slverr=%b prdata=%h want %b %h",
                               obs_slverr, obs_prdata, e.slverr, e.prdata);
        end
        apb_idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        push_exp(1, 2'b00, '0);
        apb_xfer(1, 32'h6000, 32'h11112222, 4'h3, 0, 0, 0, 0, 0, 2'b00, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge ACLK);
            push_exp(0, 2'b00, 32'hB0B0_0000 + 32'(i));
            apb_xfer(0, 32'h6100 + 32'(i * 4), '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hB0B0_0000 + 32'(i));
            n_checks++;
            if (trace[0] !== 0 || obs_done !== 3) begin
                n_fail++; $display("FAIL b2b_accept[%0d]: got start_state=%0d pready=%0d want 0 3",
                                   i, trace[0], obs_done);
            end
        end
        for (int i = 0; i < 3; i++) begin
            e = sb.pop_front();
            if (i == 2) begin
                n_checks++;
                if (obs_prdata !== e.prdata || obs_slverr !== e.slverr) begin
                    n_fail++; $display("FAIL b2b_last: got prdata=%h slverr=%b want %h %b",
                                       obs_prdata, obs_slverr, e.prdata, e.slverr);
                end
            end
        end
        apb_idle();
        // a write must not disturb PRDATA
        push_exp(1, 2'b00, '0);
        apb_xfer(1, 32'h6200, 32'h33334444, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'hFFFFFFFF);
        e = sb.pop_front();
        n_checks++;
        if (obs_prdata !== e.prdata) begin
            n_fail++; $display("FAIL wr_keeps_prdata: got %h want %h", obs_prdata, e.prdata);
        end
        apb_idle();
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        bus.PSEL = 1; bus.PENABLE = 0; bus.PWRITE = 1;
        bus.PADDR = 32'h7000; bus.PWDATA = 32'h99998888; bus.PSTRB = 4'hC;
        @(negedge ACLK);
        bus.PENABLE = 1;
        n_checks++;
        if (state !== 3'd1 || bus.AWVALID !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got state=%0d awvalid=%b want 1 1", state, bus.AWVALID);
        end
        #2 ARESET = 1;
        #1;
        n_checks++;
        if ({bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY, bus.PREADY, bus.PSLVERR,
             bus.PRDATA, bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, state} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got state=%0d awvalid=%b wvalid=%b awaddr=%h wdata=%h prdata=%h want all zero",
                     state, bus.AWVALID, bus.WVALID, bus.AWADDR, bus.WDATA, bus.PRDATA);
        end
        m_prdata = '0;
        clear_inputs();
        @(negedge ACLK);
        ARESET = 0;
        @(negedge ACLK);
        push_exp(0, 2'b00, 32'hC0FFEE00);
        apb_xfer(0, 32'h3000, '0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hC0FFEE00);
        e = sb.pop_front();
        n_checks++;
        if (obs_done !== 3 || obs_prdata !== e.prdata || obs_slverr !== e.slverr || stable_ok !== 1'b1) begin
            n_fail++; $display("FAIL rst_then_read: got done=%0d prdata=%h slverr=%b stable=%b want 3 %h %b 1",
                               obs_done, obs_prdata, obs_slverr, stable_ok, e.prdata, e.slverr);
        end
        apb_idle();
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_zero_wait();
        test_split_write();
        test_error_mapping();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
